// File: rtl/multi_channel_counter_stream.sv
// multi_channel_counter_stream
// Holds NCH independent WIDTH-bit counters. Their values are streamed over one
// registered valid/ready output port, and the channels are served round-robin.
// Optional feature macro: MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN. When it is
// defined, each counter saturates and then stops requesting until it is cleared.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data and out_chan are held
// stable. The register reloads whenever it is empty or being drained, so
// back-to-back words flow with no bubble.
module multi_channel_counter_stream #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CHW-1:0]   out_chan,
  output logic             busy
);

  logic [WIDTH-1:0] cnt [NCH];
  logic [CHW-1:0]   ptr;
  logic [NCH-1:0]   req;
  logic [CHW-1:0]   win;
  logic [CHW-1:0]   win_hi;
  logic [CHW-1:0]   win_lo;
  logic             hit_hi;
  logic [WIDTH-1:0] win_data;
  logic [CHW-1:0]   ptr_nxt;
  logic             load;

`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
  logic [NCH-1:0] sat;
  // A saturated channel has already emitted its max value, so it drops out of arbitration.
  assign req = en & ~sat;
`else
  assign req = en;
`endif

  // Round-robin pick. Take the lowest requester at or above ptr; if there is none, take the lowest overall.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hit_hi = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = CHW'(i);
        if (CHW'(i) >= ptr) begin
          win_hi = CHW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    win = hit_hi ? win_hi : win_lo;
  end

  // Select the winner's counter value, and advance the pointer past the winner modulo NCH.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CHW'(i) == win) win_data = cnt[i];
    end
    ptr_nxt = (win == CHW'(NCH - 1)) ? '0 : win + CHW'(1);
  end

  assign load = (!out_valid || out_ready) && (|req);
  assign busy = out_valid;

  // Output register and pointer. Hold on stall; empty after an accept when nothing is requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_chan  <= win;
      ptr       <= ptr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-channel counters. Clear takes priority over the increment that follows a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
        sat[i] <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clear[i]) begin
          cnt[i] <= '0;
`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
          sat[i] <= 1'b0;
`endif
        end else if (load && (win == CHW'(i))) begin
`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
          if (cnt[i] != '1) cnt[i] <= cnt[i] + WIDTH'(1);
          if (cnt[i] == '1) sat[i] <= 1'b1;
`else
          cnt[i] <= cnt[i] + WIDTH'(1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_counter_stream.sv
// Testbench for multi_channel_counter_stream.
// Main instance: WIDTH=8, NCH=4. Second instance: WIDTH=1, NCH=1.
module tb_multi_channel_counter_stream;

  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  en, clr;
  logic          rdy;
  logic          out_valid, busy;
  logic [W-1:0]  out_data;
  logic [1:0]    out_chan;

  logic en1, clr1, rdy1, v1, d1, c1, b1;

  multi_channel_counter_stream #(.WIDTH(W), .NCH(N)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clr), .out_ready(rdy),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .busy(busy)
  );

  multi_channel_counter_stream #(.WIDTH(1), .NCH(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .clear(clr1), .out_ready(rdy1),
    .out_valid(v1), .out_data(d1), .out_chan(c1), .busy(b1)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    logic         rdy;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   ec;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic r, input logic [N-1:0] e, input logic [N-1:0] c,
                     input logic rd, input logic ev, input logic [W-1:0] ed, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.rdy = rd; v.ev = ev; v.ed = ed; v.ec = ec;
    vec.push_back(v);
  endtask

  // ---------------- scoreboard model ----------------
  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_cnt [N];
  logic [N-1:0] m_sat;
  logic [1:0]   m_ptr;
  logic         m_valid;

  task automatic model_step(input logic [N-1:0] e, input logic [N-1:0] c, input logic rd);
    logic [N-1:0] rq;
    logic         ld;
    int           w;
    rq = e & ~m_sat;
    ld = (!m_valid || rd) && (rq != 0);
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && rq[(int'(m_ptr) + k) % N]) w = (int'(m_ptr) + k) % N;
    end
    if (ld) begin
      exp_q.push_back({2'(w), m_cnt[w]});
      m_valid = 1'b1;
      m_ptr = 2'((w + 1) % N);
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        m_cnt[i] = '0;
        m_sat[i] = 1'b0;
      end else if (ld && w == i) begin
`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
        if (m_cnt[i] == '1) m_sat[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1'b1;
`else
        m_cnt[i] = m_cnt[i] + 1'b1;
`endif
      end
    end
  endtask

  task automatic sb_accept_check();
    logic [W+1:0] e;
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[W-1:0]));
        chk("sb_chan", 32'(out_chan), 32'(e[W+1:W]));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = '0; clr = '0; rdy = 1'b1;
    en1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b1;

    // reset
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    // single channel, latency 1, back-to-back counting
    add(0, 4'h1, 4'h0, 1, 1, 0, 0);
    add(0, 4'h1, 4'h0, 1, 1, 1, 0);
    add(0, 4'h1, 4'h0, 1, 1, 2, 0);
    add(0, 4'h1, 4'h0, 1, 1, 3, 0);
    add(0, 4'h1, 4'h0, 1, 1, 4, 0);
    // accepted with no requester: empties, data/chan hold
    add(0, 4'h0, 4'h0, 1, 0, 4, 0);
    // round-robin fairness
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 4'hF, 4'h0, 1, 1, W'(k / 4), 2'(k % 4));
    // stall with two requesters
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h3, 4'h0, 0, 1, 0, 0);
    add(0, 4'h3, 4'h0, 0, 1, 0, 0);
    add(0, 4'h3, 4'h0, 0, 1, 0, 0);
    add(0, 4'h3, 4'h0, 1, 1, 0, 1);
    add(0, 4'h3, 4'h0, 1, 1, 1, 0);
    add(0, 4'h3, 4'h0, 1, 1, 1, 1);
    // clear in the same cycle as the load: old value out, counter restarts at 0
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 4'h4, 4'h0, 1, 1, W'(k), 2);
    add(0, 4'h4, 4'h4, 1, 1, 7, 2);
    add(0, 4'h4, 4'h0, 1, 1, 0, 2);
    add(0, 4'h4, 4'h0, 1, 1, 1, 2);
    // reset during a stall discards the word and zeroes counters
    add(0, 4'h0, 4'h0, 0, 1, 1, 2);
    add(1, 4'h3, 4'h0, 1, 0, 0, 0);
    add(0, 4'h4, 4'h0, 1, 1, 0, 2);
    // clear while the word sits stalled: register unchanged, counter zeroed
    add(0, 4'h0, 4'h4, 0, 1, 0, 2);
    add(0, 4'h4, 4'h0, 1, 1, 0, 2);
    // en dropped before a load: no word
    add(0, 4'h0, 4'h0, 1, 0, 0, 2);

    for (int k = 0; k < vec.size(); k++) begin
      rst = vec[k].rst; en = vec[k].en; clr = vec[k].clr; rdy = vec[k].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vec[k].ev));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vec[k].ev));
      chk($sformatf("vec%0d_data", k), 32'(out_data), 32'(vec[k].ed));
      chk($sformatf("vec%0d_chan", k), 32'(out_chan), 32'(vec[k].ec));
    end

    // WIDTH=1, NCH=1 instance
    rst = 1'b1; en = '0; clr = '0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("w1_reset_valid", 32'(v1), 32'(0));
    rst = 1'b0; en1 = 1'b1; rdy1 = 1'b1;
`ifdef MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w1_sat_valid%0d", k), 32'(v1), 32'(1));
      chk($sformatf("w1_sat_data%0d", k), 32'(d1), 32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w1_sat_stop%0d", k), 32'(v1), 32'(0));
    end
    clr1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_sat_clr_cycle", 32'(v1), 32'(0));
    clr1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_sat_restart_valid", 32'(v1), 32'(1));
    chk("w1_sat_restart_data", 32'(d1), 32'(0));
`else
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w1_valid%0d", k), 32'(v1), 32'(1));
      chk($sformatf("w1_data%0d", k), 32'(d1), 32'(k % 2));
      chk($sformatf("w1_chan%0d", k), 32'(c1), 32'(0));
      chk($sformatf("w1_busy%0d", k), 32'(b1), 32'(1));
    end
`endif
    en1 = 1'b0;

    // random traffic against the scoreboard
    rst = 1'b1; en = '0; clr = '0; rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_sat = '0; m_ptr = '0; m_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      en  = N'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      rdy = ($urandom_range(0, 3) != 0);
      sb_accept_check();
      model_step(en, clr, rdy);
      @(posedge clk); #1;
      chk("sb_valid", 32'(out_valid), 32'(m_valid));
    end
    // drain
    en = '0; clr = '0; rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      sb_accept_check();
      model_step(en, clr, rdy);
      @(posedge clk); #1;
    end
    chk("sb_drained_valid", 32'(out_valid), 32'(0));
    chk("sb_queue_left", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_counter_stream.md
Name: multi_channel_counter_stream

Overview:
- Parametrised successor to the single-bit toggling counter that drives a data/valid bus.
- Holds NCH independent WIDTH-bit counters and streams their values over one registered valid/ready output.
- Channels are arbitrated round-robin.
- Serves as a traffic source and testbench driver for bus/interface conversion tests, and as a synthesizable stimulus block.

Parameters:
- WIDTH, 8, counter and data width in bits (>=1; WIDTH=1 reproduces the toggle behaviour per channel).
- NCH, 4, number of counter channels (>=1).
- CHW, derived localparam = max(1, clog2(NCH)), channel index width (not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  NCH  per-channel request enable; channel i competes for the output while en[i]=1.
- clear  input  NCH  per-channel synchronous counter clear.
- out_ready  input  1  downstream accepts the word when high together with out_valid.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  counter value carried by the word.
- out_chan  output  CHW  index of the channel that produced the word.
- busy  output  1  equals out_valid.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: cnt[i]=0 for all i; out_valid=0; out_data=0; out_chan=0; busy=0; round-robin pointer=0, so channel 0 has highest priority first.
- Request vector: req[i] = en[i] (further masked under the optional feature).
- Load condition: load = (!out_valid || out_ready) && |req.
  - Winner = first i with req[i]=1, searching from the pointer upward and wrapping modulo NCH.
  - On load: out_data<=cnt[winner], out_chan<=winner, out_valid<=1, cnt[winner]<=cnt[winner]+1 (mod 2^WIDTH wrap), pointer<=(winner+1) mod NCH.
- Empty after accept: if out_valid && out_ready && !|req, then out_valid<=0; out_data and out_chan hold their last value.
- Stall: out_valid && !out_ready means out_valid, out_data and out_chan stay stable; no counter changes except clear; the pointer holds.
- Latency: en[i] asserted in cycle N, output empty, no competitors, gives out_valid=1 with that channel's word in cycle N+1.
- Throughput: with out_ready held high, one word per cycle (back-to-back, no bubble).
- Fairness: with all en high and out_ready high, out_chan sequence is 0,1,...,NCH-1,0,... Each channel is served at most once per NCH consecutive loads while others request.
- clear[i]=1: cnt[i]<=0 next cycle.
  - Clear has priority over increment when channel i is loaded in the same cycle.
  - That loaded word carries the pre-clear value.
  - A word already in the output register is never altered by clear.
- en[i] dropped after its word is loaded: the word is still delivered.
- en[i] dropped before a load: no word for channel i.
- NCH=1: the pointer is constant 0 and out_chan is always 0.
- rst asserted mid-stall: next cycle out_valid=0, the pending word is discarded, and all counters are 0. No handshake completes in the reset cycle (out_ready is ignored).

Optional Feature:
- Macro: MULTI_CHANNEL_COUNTER_STREAM_SATURATE_EN.
- Defined:
  - Counters saturate at 2^WIDTH-1 instead of wrapping.
  - A sat[i] flag sets when channel i is loaded with value 2^WIDTH-1.
  - req[i] = en[i] && !sat[i], so a saturated channel emits its max value exactly once and then stops requesting.
  - clear[i] or rst resets cnt[i] and sat[i].
- Undefined: counters wrap modulo 2^WIDTH, no sat state exists, and channels request indefinitely.

Test Plan:
1. Reset, NCH=4, WIDTH=8; en=4'b0001, out_ready=1 for 5 cycles -> out_valid high from cycle 1; out_data 0,1,2,3,4; out_chan=0.
2. en=4'b1111, out_ready=1 for 8 cycles -> out_chan 0,1,2,3,0,1,2,3 and out_data 0,0,0,0,1,1,1,1.
3. en=4'b0011, out_ready=0 for 3 cycles, then 1 -> first word (chan 0, data 0) held stable during the stall; cnt[1] still 0; then chan 1 data 0, chan 0 data 1.
4. WIDTH=1, NCH=1, en=1, out_ready=1 -> out_data 0,1,0,1 (wrap). With the macro defined -> 0,1, then out_valid=0 until clear[0] pulses, after which 0 is emitted again.
5. clear[2] in the same cycle as the chan 2 load while cnt[2]=7 -> emitted word has data 7; chan 2's next word has data 0.
6. rst during a stall with out_valid=1 -> next cycle out_valid=0 and all counters 0; after rst deasserts with en=4'b0100, the first word is chan 2, data 0.
